// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers feature vectors in a small FIFO and feeds them to a
// systolic array with a per-row skew (row r lags row 0 by r cycles). A tile is
// closed by the vector marked in_last; the FSM waits for the skew to drain
// before raising done.
//
// state  | meaning
// IDLE   | no tile in progress, pops allowed
// STREAM | tile in progress, pops allowed
// DRAIN  | last vector popped, waiting for skew pipeline to empty
// DONE   | one-cycle done pulse, then back to IDLE

module systolic_feeder #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 3,
    parameter int DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    nrst_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*WIDTH-1:0]   in_data,
    input  logic                    in_last,
    input  logic                    stall_in,
    output logic [ROWS*WIDTH-1:0]   feat_out,
    output logic [ROWS-1:0]         feat_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    logic [ROWS*WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    state_t                state;
    logic [DW-1:0]         drain_cnt;

    logic                  push;
    logic                  pop;
    logic [ROWS*WIDTH:0]   head;
    logic                  head_last;
    logic [ROWS*WIDTH-1:0] head_data;

    assign in_ready  = (count < DEPTH_C);
    assign push      = in_valid && in_ready;
    assign pop       = !stall_in && (count != '0) && ((state == IDLE) || (state == STREAM));
    assign head      = mem[rd_ptr];
    assign head_last = head[ROWS*WIDTH];
    assign head_data = head[ROWS*WIDTH-1:0];
    assign busy      = (state != IDLE) || (count != '0);

    // FIFO storage; contents need no reset because pointers/count gate every read
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tile sequencing: stream until the last vector is popped, then drain the skew
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, STREAM: begin
                    done <= 1'b0;
                    if (pop) begin
                        if (head_last) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall_in) begin
                        if (drain_cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [WIDTH-1:0] dl [0:r];
        logic [r:0]       vl;

        // Lane r delay line of r+1 registers; bubbles shift in when nothing is popped
        always_ff @(posedge clk_in or negedge nrst_in) begin
            if (!nrst_in) begin
                for (int k = 0; k <= r; k++) begin
                    dl[k] <= '0;
                end
                vl <= '0;
            end else if (!stall_in) begin
                dl[0] <= pop ? head_data[r*WIDTH +: WIDTH] : '0;
                vl[0] <= pop;
                for (int k = 1; k <= r; k++) begin
                    dl[k] <= dl[k-1];
                    vl[k] <= vl[k-1];
                end
            end
        end

        assign feat_out[r*WIDTH +: WIDTH] = dl[r];
        assign feat_valid[r]              = vl[r];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: directed tiles, stalls, full FIFO and reset,
// with a per-lane scoreboard and a skew-timing monitor.

module tb_systolic_feeder;

    localparam int WIDTH = 8;
    localparam int ROWS  = 3;
    localparam int DEPTH = 4;

    logic                  clk;
    logic                  nrst;
    logic                  in_valid;
    logic                  in_ready;
    logic [ROWS*WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  stall_in;
    logic [ROWS*WIDTH-1:0] feat_out;
    logic [ROWS-1:0]       feat_valid;
    logic                  busy;
    logic                  done;

    systolic_feeder #(.WIDTH(WIDTH), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk_in     (clk),
        .nrst_in    (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .stall_in   (stall_in),
        .feat_out   (feat_out),
        .feat_valid (feat_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q  [ROWS][$];
    int         skew_q [ROWS][$];
    int         nsc = 0;
    bit         adv = 1'b0;
    int         done_cnt = 0;
    bit         prev_done = 1'b0;
    int         exp_done_33 = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // edge bookkeeping: which edges advanced the skew pipeline
    always @(posedge clk) begin
        adv = nrst && !stall_in;
        if (adv) nsc++;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (nrst) begin
            if (adv) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (feat_valid[r]) begin
                        logic [7:0] lane;
                        lane = feat_out[r*WIDTH +: WIDTH];
                        if (exp_q[r].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL lane%0d_unexpected got %h want none", r, lane);
                        end else begin
                            check($sformatf("lane%0d_data", r), {24'h0, lane}, {24'h0, exp_q[r].pop_front()});
                        end
                        if (r > 0) begin
                            if (skew_q[r].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL lane%0d_skew got emission want none", r);
                            end else begin
                                check($sformatf("lane%0d_skew", r), nsc, skew_q[r].pop_front());
                            end
                        end
                        if (r < ROWS - 1) skew_q[r+1].push_back(nsc + 1);
                        if (r == 0 && lane == 8'h33) check("tile2_after_done", done_cnt, exp_done_33);
                    end
                end
            end
            if (done) begin
                check("done_one_cycle", {31'h0, prev_done}, 32'h0);
                done_cnt++;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // caller sits at a negedge; returns at the negedge after the push edge
    task automatic push(input logic [23:0] d, input bit last, input bit exp_acc);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        #1;
        check("in_ready", {31'h0, in_ready}, {31'h0, exp_acc});
        @(posedge clk);
        if (exp_acc) begin
            for (int r = 0; r < ROWS; r++) exp_q[r].push_back(d[r*WIDTH +: WIDTH]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'h0, ok}, 32'h1);
    endtask

    task automatic clear_sb();
        for (int r = 0; r < ROWS; r++) begin
            exp_q[r].delete();
            skew_q[r].delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        nrst     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        stall_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_feat_out", {8'h0, feat_out}, 32'h0);
        check("rst_feat_valid", {29'h0, feat_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        nrst = 1'b1;
        @(negedge clk);

        // single vector, exact timing
        push(24'h030201, 1'b1, 1'b1);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_fv_e0", {29'h0, feat_valid}, 32'h0);
        @(negedge clk);
        check("t1_fv_e1", {29'h0, feat_valid}, 32'h1);
        check("t1_l0_e1", {24'h0, feat_out[7:0]}, 32'h01);
        @(negedge clk);
        check("t1_fv_e2", {29'h0, feat_valid}, 32'h2);
        check("t1_l1_e2", {24'h0, feat_out[15:8]}, 32'h02);
        @(negedge clk);
        check("t1_fv_e3", {29'h0, feat_valid}, 32'h4);
        check("t1_l2_e3", {24'h0, feat_out[23:16]}, 32'h03);
        check("t1_done_e3", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("t1_done_e4", {31'h0, done}, 32'h1);
        check("t1_fv_e4", {29'h0, feat_valid}, 32'h0);
        @(negedge clk);
        check("t1_done_e5", {31'h0, done}, 32'h0);
        check("t1_busy_e5", {31'h0, busy}, 32'h0);
        check("t1_done_cnt", done_cnt, 1);

        // back-to-back tile
        base = done_cnt;
        push(24'h010101, 1'b0, 1'b1);
        push(24'h020202, 1'b0, 1'b1);
        push(24'h030303, 1'b0, 1'b1);
        push(24'h040404, 1'b1, 1'b1);
        wait_idle(40);
        check("t2_done_cnt", done_cnt, base + 1);

        // full FIFO under stall
        base = done_cnt;
        stall_in = 1'b1;
        push(24'h151515, 1'b0, 1'b1);
        push(24'h262626, 1'b0, 1'b1);
        push(24'h373737, 1'b0, 1'b1);
        push(24'h484848, 1'b1, 1'b1);
        push(24'h595959, 1'b1, 1'b0);
        check("t3_fv_frozen", {29'h0, feat_valid}, 32'h0);
        check("t3_no_done", done_cnt, base);
        stall_in = 1'b0;
        wait_idle(40);
        check("t3_done_cnt", done_cnt, base + 1);

        // stall mid-skew
        base = done_cnt;
        push(24'h030201, 1'b1, 1'b1);
        @(negedge clk);
        check("t4_l0", {24'h0, feat_out[7:0]}, 32'h01);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_fv", {29'h0, feat_valid}, 32'h1);
            check("t4_hold_out", {8'h0, feat_out}, 32'h000001);
        end
        stall_in = 1'b0;
        @(negedge clk);
        check("t4_resume_fv", {29'h0, feat_valid}, 32'h2);
        check("t4_resume_l1", {24'h0, feat_out[15:8]}, 32'h02);
        wait_idle(40);
        check("t4_done_cnt", done_cnt, base + 1);

        // reset mid-tile
        base = done_cnt;
        push(24'h0a0a0a, 1'b1, 1'b1);
        push(24'h0b0b0b, 1'b0, 1'b1);
        push(24'h0c0c0c, 1'b1, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        check("t5_feat_out", {8'h0, feat_out}, 32'h0);
        check("t5_feat_valid", {29'h0, feat_valid}, 32'h0);
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_in_ready", {31'h0, in_ready}, 32'h1);
        check("t5_done", {31'h0, done}, 32'h0);
        clear_sb();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_done", done_cnt, base);
        check("t5_idle", {31'h0, busy}, 32'h0);

        // two tiles back to back
        base = done_cnt;
        exp_done_33 = base + 1;
        push(24'h111111, 1'b0, 1'b1);
        push(24'h222222, 1'b1, 1'b1);
        push(24'h333333, 1'b0, 1'b1);
        push(24'h444444, 1'b1, 1'b1);
        wait_idle(60);
        check("t6_done_cnt", done_cnt, base + 2);

        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("lane%0d_drained", r), exp_q[r].size(), 0);
        end
        check("total_done", done_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
